// File: rtl/nonce_ticket_hub.sv
// nonce_ticket_hub: gathers golden nonces from several hashing cores. Each core's ticket
// rising edge captures its nonce into a per-core pending slot. A round-robin arbiter moves
// pending slots into a small result FIFO tagged with the core id, and the FIFO drains
// through a valid/ready port. Also produces a write pulse for the LED fader and
// found/dropped statistics.
module nonce_ticket_hub #(
   parameter int unsigned SLAVES     = 4,
   parameter int unsigned ID_W       = 2,
   parameter int unsigned NONCE_W    = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DROP_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SLAVES-1:0]           got_ticket,
   input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NONCE_W-1:0]          out_nonce,
   output logic [ID_W-1:0]             out_slave,
   output logic                        new_nonce,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [31:0]                 nonce_count,
   output logic [DROP_W-1:0]           drop_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ENT_W = ID_W + NONCE_W;
   localparam int unsigned INC_W = $clog2(SLAVES + 1);
   localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(FIFO_DEPTH);

   // Ticket edge detection
   logic [SLAVES-1:0]  prev_ticket_q, prev_ticket_d;
   logic [SLAVES-1:0]  rise;

   // Per-core pending slots
   logic [SLAVES-1:0]  pend_q, pend_d;
   logic [NONCE_W-1:0] pend_nonce_q [SLAVES];
   logic [NONCE_W-1:0] pend_nonce_d [SLAVES];

   // Arbiter
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_idx;
   logic               found_hi, found_any;
   logic [ID_W-1:0]    idx_hi, idx_any;

   // Result FIFO
   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               push, pop, push_ok;
   logic [ENT_W-1:0]   head;

   // Statistics
   logic [31:0]        nonce_count_q, nonce_count_d;
   logic [DROP_W-1:0]  drop_count_q, drop_count_d;
   logic [DROP_W:0]    drop_sum;
   logic [INC_W-1:0]   drop_inc;
   logic               new_nonce_q, new_nonce_d;

   // Head of FIFO and handshake qualifiers
   always_comb begin
      head      = mem_q[rd_ptr_q];
      out_valid = (level_q != '0);
      out_slave = head[ENT_W-1 -: ID_W];
      out_nonce = head[NONCE_W-1:0];
      pop       = out_valid & out_ready;
      // A same-cycle pop frees the slot being written, so a full FIFO can still accept
      push_ok   = (level_q < DepthLvl) | pop;
   end

   // Round-robin pick: lowest pending index above last grant, else lowest pending overall
   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      idx_hi    = '0;
      idx_any   = '0;
      for (int unsigned i = 0; i < SLAVES; i++) begin
         if (pend_q[i] && !found_any) begin
            found_any = 1'b1;
            idx_any   = ID_W'(i);
         end
         if (pend_q[i] && !found_hi && (ID_W'(i) > last_grant_q)) begin
            found_hi = 1'b1;
            idx_hi   = ID_W'(i);
         end
      end
      grant_idx    = found_hi ? idx_hi : idx_any;
      grant_vld    = found_any & push_ok;
      push         = grant_vld;
      last_grant_d = grant_vld ? grant_idx : last_grant_q;
   end

   // Edge detect, pending capture and overwrite accounting
   always_comb begin
      rise          = got_ticket & ~prev_ticket_q;
      prev_ticket_d = got_ticket;
      pend_d        = pend_q;
      pend_nonce_d  = pend_nonce_q;
      drop_inc      = '0;
      if (grant_vld) begin
         pend_d[grant_idx] = 1'b0;
      end
      // A new capture overrides a same-cycle grant clear; only an undrained slot counts a drop
      for (int unsigned i = 0; i < SLAVES; i++) begin
         if (rise[i]) begin
            pend_d[i]       = 1'b1;
            pend_nonce_d[i] = slave_nonces[i*NONCE_W +: NONCE_W];
            if (pend_q[i] && !(grant_vld && (grant_idx == ID_W'(i)))) begin
               drop_inc = drop_inc + INC_W'(1);
            end
         end
      end
   end

   // FIFO pointers, occupancy, storage and statistics next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = {grant_idx, pend_nonce_q[grant_idx]};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      nonce_count_d = nonce_count_q + 32'(push);
      new_nonce_d   = push;
      drop_sum      = {1'b0, drop_count_q} + (DROP_W+1)'(drop_inc);
      drop_count_d  = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
   end

   // Output register mirrors
   always_comb begin
      new_nonce   = new_nonce_q;
      fifo_level  = level_q;
      nonce_count = nonce_count_q;
      drop_count  = drop_count_q;
   end

   // Control state; prev_ticket resets high so a ticket held through reset never captures
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_ticket_q <= '1;
         pend_q        <= '0;
         last_grant_q  <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         nonce_count_q <= '0;
         drop_count_q  <= '0;
         new_nonce_q   <= 1'b0;
         for (int unsigned i = 0; i < SLAVES; i++) begin
            pend_nonce_q[i] <= '0;
         end
      end else begin
         prev_ticket_q <= prev_ticket_d;
         pend_q        <= pend_d;
         last_grant_q  <= last_grant_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         nonce_count_q <= nonce_count_d;
         drop_count_q  <= drop_count_d;
         new_nonce_q   <= new_nonce_d;
         pend_nonce_q  <= pend_nonce_d;
      end
   end

   // FIFO storage needs no reset; validity is tracked by level_q
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_nonce_ticket_hub.sv
// Bench for nonce_ticket_hub: directed stimulus with a scoreboard queue of expected
// {slave, nonce} entries checked by a monitor on every accepted FIFO head.
module tb_nonce_ticket_hub;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] nonce;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [3:0]   got_ticket;
   logic [127:0] slave_nonces;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_nonce;
   logic [1:0]   out_slave;
   logic         new_nonce;
   logic [3:0]   fifo_level;
   logic [31:0]  nonce_count;
   logic [15:0]  drop_count;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks;
   int   n_fail;

   nonce_ticket_hub dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .got_ticket   (got_ticket),
      .slave_nonces (slave_nonces),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_nonce    (out_nonce),
      .out_slave    (out_slave),
      .new_nonce    (new_nonce),
      .fifo_level   (fifo_level),
      .nonce_count  (nonce_count),
      .drop_count   (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nonce(input int ch, input logic [31:0] v);
      slave_nonces[ch*32 +: 32] = v;
   endtask

   task automatic expect_entry(input logic [1:0] id, input logic [31:0] v);
      exp_t e;
      e.id    = id;
      e.nonce = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      check("drain_complete", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every accepted head must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got slave %0d nonce %0h, expected nothing",
                     out_slave, out_nonce);
         end else begin
            mon_e = exp_q.pop_front();
            check("head_slave", 64'(out_slave), 64'(mon_e.id));
            check("head_nonce", 64'(out_nonce), 64'(mon_e.nonce));
         end
      end
   end

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      got_ticket   = '0;
      slave_nonces = '0;
      out_ready    = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_nonce_count", 64'(nonce_count), 64'd0);
      check("rst_drop_count", 64'(drop_count), 64'd0);
      check("rst_new_nonce", 64'(new_nonce), 64'd0);
      rst_n = 1'b1;
      tick();
      tick();

      // Single capture on ch2
      set_nonce(2, 32'hDEADBEEF);
      out_ready  = 1'b1;
      got_ticket = 4'b0100;
      expect_entry(2'd2, 32'hDEADBEEF);
      tick();
      check("t1_valid_early", 64'(out_valid), 64'd0);
      tick();
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_new_nonce", 64'(new_nonce), 64'd1);
      check("t1_slave", 64'(out_slave), 64'd2);
      check("t1_nonce", 64'(out_nonce), 64'hDEADBEEF);
      check("t1_count", 64'(nonce_count), 64'd1);
      tick();
      check("t1_pulse_end", 64'(new_nonce), 64'd0);
      check("t1_empty", 64'(out_valid), 64'd0);
      got_ticket = '0;
      tick();

      // Round-robin from last_grant=0 after a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_nonce(i, 32'h10 + 32'(i));
      got_ticket = 4'b1111;
      expect_entry(2'd1, 32'h11);
      expect_entry(2'd2, 32'h12);
      expect_entry(2'd3, 32'h13);
      expect_entry(2'd0, 32'h10);
      tick();
      check("t2_level0", 64'(fifo_level), 64'd0);
      got_ticket = '0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("t2_level", 64'(fifo_level), 64'(k));
         check("t2_new_nonce", 64'(new_nonce), 64'd1);
      end
      check("t2_count", 64'(nonce_count), 64'd4);
      tick();
      check("t2_peak", 64'(fifo_level), 64'd4);
      check("t2_pulse_end", 64'(new_nonce), 64'd0);
      out_ready = 1'b1;
      wait_drain();
      tick();
      check("t2_level_end", 64'(fifo_level), 64'd0);

      // Backpressure: 10 rises on ch0/ch1 into a FIFO of 8
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         set_nonce(0, 32'h100 + 32'(j));
         set_nonce(1, 32'h200 + 32'(j));
         expect_entry(2'd1, 32'h200 + 32'(j));
         expect_entry(2'd0, 32'h100 + 32'(j));
         got_ticket = 4'b0011;
         tick();
         got_ticket = 4'b0000;
         tick();
      end
      check("t3_level_full", 64'(fifo_level), 64'd8);
      check("t3_count", 64'(nonce_count), 64'd12);
      check("t3_drop", 64'(drop_count), 64'd0);
      tick();
      check("t3_level_hold", 64'(fifo_level), 64'd8);

      // Full FIFO with pop and push in the same cycle
      out_ready = 1'b1;
      tick();
      check("t4_level_stays", 64'(fifo_level), 64'd8);
      check("t4_count", 64'(nonce_count), 64'd13);
      check("t4_new_nonce", 64'(new_nonce), 64'd1);
      wait_drain();
      tick();
      check("t4_level_end", 64'(fifo_level), 64'd0);
      check("t4_count_end", 64'(nonce_count), 64'd14);

      // Overwrite race: ch1 grant coincides with a new ch1 rise
      set_nonce(1, 32'h300);
      expect_entry(2'd1, 32'h300);
      got_ticket = 4'b0010;
      tick();
      got_ticket = 4'b0000;
      tick();
      tick();
      set_nonce(1, 32'h301);
      set_nonce(2, 32'h400);
      expect_entry(2'd2, 32'h400);
      expect_entry(2'd1, 32'h301);
      expect_entry(2'd1, 32'h302);
      got_ticket = 4'b0110;
      tick();
      got_ticket = 4'b0000;
      tick();
      set_nonce(1, 32'h302);
      got_ticket = 4'b0010;
      tick();
      check("t5_no_drop", 64'(drop_count), 64'd0);
      got_ticket = 4'b0000;
      tick();
      wait_drain();
      check("t5_no_drop_end", 64'(drop_count), 64'd0);

      // Two overwrites in one cycle while waiting behind other cores
      for (int i = 0; i < 4; i++) set_nonce(i, 32'h500 + 32'(i));
      expect_entry(2'd2, 32'h502);
      expect_entry(2'd3, 32'h503);
      expect_entry(2'd0, 32'h510);
      expect_entry(2'd1, 32'h511);
      got_ticket = 4'b1111;
      tick();
      got_ticket = 4'b0000;
      tick();
      set_nonce(0, 32'h510);
      set_nonce(1, 32'h511);
      got_ticket = 4'b0011;
      tick();
      check("t5_drop2", 64'(drop_count), 64'd2);
      got_ticket = 4'b0000;
      tick();
      wait_drain();
      check("t5_drop_end", 64'(drop_count), 64'd2);

      // Reset with 5 queued entries and a ticket held across reset
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         set_nonce(0, 32'h600 + 32'(j));
         got_ticket = 4'b0001;
         tick();
         got_ticket = 4'b0000;
         tick();
      end
      check("t6_level5", 64'(fifo_level), 64'd5);
      set_nonce(3, 32'h777);
      got_ticket = 4'b1000;
      rst_n      = 1'b0;
      exp_q.delete();
      tick();
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_level", 64'(fifo_level), 64'd0);
      check("t6_rst_count", 64'(nonce_count), 64'd0);
      check("t6_rst_drop", 64'(drop_count), 64'd0);
      check("t6_rst_pulse", 64'(new_nonce), 64'd0);
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t6_no_capture_valid", 64'(out_valid), 64'd0);
         check("t6_no_capture_pulse", 64'(new_nonce), 64'd0);
      end
      check("t6_count_after", 64'(nonce_count), 64'd0);
      got_ticket = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
